// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out framer, LSB first, followed by EXTRA_BITS zero pad bits.
// Ports: clk, rst (sync, active high); load/din start a frame when idle;
//        dout/dvalid carry the frame bits; busy is high while a frame is in flight.
module piso_shift_reg #(
    parameter int WIDTH      = 42,
    parameter int EXTRA_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             dout,
    output logic             dvalid,
    output logic             busy
);
    localparam int TOT = WIDTH + EXTRA_BITS;
    localparam int CW  = $clog2(TOT + 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    // bit 0 goes out straight from din on the accepting edge; once the data
    // has shifted out the register holds zeros, which become the pad bits
    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            cnt    <= '0;
            dout   <= 1'b0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
        end else if (load && !busy) begin
            sr     <= din >> 1;
            dout   <= din[0];
            dvalid <= 1'b1;
            busy   <= 1'b1;
            cnt    <= CW'(1);
        end else if (busy) begin
            if (cnt == CW'(TOT)) begin
                dout   <= 1'b0;
                dvalid <= 1'b0;
                busy   <= 1'b0;
            end else begin
                dout <= sr[0];
                sr   <= sr >> 1;
                cnt  <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/piso_harness.sv
// piso_harness: serializes loaded words and reassembles them from the serial stream.
// Ports: clk, rst (sync, active high); load_valid/load_data/load_ready load handshake;
//        ser_out/ser_valid serial frame; cap_valid/cap_data reassembled word (pulse + held data).
module piso_harness #(
    parameter int WIDTH      = 42,
    parameter int EXTRA_BITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_data
);
    localparam int TOT = WIDTH + EXTRA_BITS;
    localparam int CW  = $clog2(TOT + 1);

    logic             busy;
    logic [WIDTH-1:0] cap_sr;
    logic [WIDTH-1:0] cap_nxt;
    logic [CW-1:0]    bit_cnt;
    logic             shift_en;
    logic             last;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .EXTRA_BITS(EXTRA_BITS)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (load_valid && load_ready),
        .din   (load_data),
        .dout  (ser_out),
        .dvalid(ser_valid),
        .busy  (busy)
    );

    assign load_ready = !busy;

    // only the first WIDTH frame bits are data; the last bit of the frame
    // (which is the final data bit when there is no pad) completes the word
    always_comb begin
        shift_en = ser_valid && (bit_cnt < CW'(WIDTH));
        last     = ser_valid && (bit_cnt == CW'(TOT - 1));
        cap_nxt  = shift_en ? ((cap_sr >> 1) | (WIDTH'(ser_out) << (WIDTH - 1))) : cap_sr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sr    <= '0;
            bit_cnt   <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_sr    <= cap_nxt;
            bit_cnt   <= !ser_valid ? '0 : (bit_cnt == CW'(TOT)) ? bit_cnt : bit_cnt + CW'(1);
            cap_valid <= last;
            cap_data  <= last ? cap_nxt : cap_data;
        end
    end
endmodule

// File: tb/tb_piso_harness.sv
// tb_piso_harness: directed and table-driven checks of the serializer/capture harness.
module tb_piso_harness;
    localparam int W   = 42;
    localparam int E   = 3;
    localparam int TOT = W + E;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         cap_valid;
    logic [W-1:0] cap_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    piso_harness #(.WIDTH(W), .EXTRA_BITS(E)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .cap_valid (cap_valid),
        .cap_data  (cap_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_cap;
        int           idle;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Drives one load at a negedge and follows the frame cycle by cycle.
    // Returns at the negedge of cycle TOT+1 (cap_valid cycle), or right after
    // an injected reset. glitch_at/rst_at of 0 disable those injections.
    task automatic frame(input logic [W-1:0] w, input logic [W-1:0] exp_cap,
                         input int glitch_at, input int rst_at, output int cap_cyc);
        int t = 0;
        logic eb;
        cap_cyc = -1;
        while (!load_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_before_load", 64'(load_ready), 64'(1));
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = '0;
        for (int i = 1; i <= TOT; i++) begin
            eb = (i <= W) ? w[i-1] : 1'b0;
            check("ser_valid", 64'(ser_valid), 64'(1));
            check("ser_out", 64'(ser_out), 64'(eb));
            check("cap_quiet", 64'(cap_valid), 64'(0));
            check("busy_not_ready", 64'(load_ready), 64'(0));
            if (i == glitch_at) begin
                load_valid = 1'b1;
                load_data  = W'(42'h123);
            end
            if (i == rst_at) rst = 1'b1;
            @(negedge clk);
            load_valid = 1'b0;
            if (i == rst_at) begin
                rst = 1'b0;
                check("rst_ready", 64'(load_ready), 64'(1));
                check("rst_ser_valid", 64'(ser_valid), 64'(0));
                check("rst_cap_valid", 64'(cap_valid), 64'(0));
                return;
            end
        end
        check("cap_valid", 64'(cap_valid), 64'(1));
        check("cap_data", 64'(cap_data), 64'(exp_cap));
        check("ready_with_cap", 64'(load_ready), 64'(1));
        check("idle_ser_valid", 64'(ser_valid), 64'(0));
        check("idle_ser_out", 64'(ser_out), 64'(0));
        cap_cyc = cyc;
    endtask

    initial begin
        int c1, c2, gap, seen;
        logic [W-1:0] w;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (7) @(negedge clk);
        check("reset_ready", 64'(load_ready), 64'(1));
        check("reset_ser_valid", 64'(ser_valid), 64'(0));
        check("reset_ser_out", 64'(ser_out), 64'(0));
        check("reset_cap_valid", 64'(cap_valid), 64'(0));
        check("reset_cap_data", 64'(cap_data), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{42'h2AAAAAAAAAA, 42'h2AAAAAAAAAA, 0};
        vecs[1] = '{42'h00000000155, 42'h00000000155, 3};
        vecs[2] = '{42'h15555555555, 42'h15555555555, 1};
        vecs[3] = '{42'h00000000000, 42'h00000000000, 2};
        vecs[4] = '{42'h3FFFFFFFFFF, 42'h3FFFFFFFFFF, 0};
        vecs[5] = '{42'h20000000001, 42'h20000000001, 5};
        for (int v = 0; v < 6; v++) begin
            frame(vecs[v].word, vecs[v].exp_cap, 0, 0, c1);
            @(negedge clk);
            check("cap_one_cycle", 64'(cap_valid), 64'(0));
            check("cap_held", 64'(cap_data), 64'(vecs[v].exp_cap));
            repeat (vecs[v].idle) @(negedge clk);
        end

        // back-to-back: second load lands on the cap_valid edge
        frame(42'h3FFFFFFFFFF, 42'h3FFFFFFFFFF, 0, 0, c1);
        frame(42'h00000000001, 42'h00000000001, 0, 0, c2);
        check("b2b_spacing", 64'(c2 - c1), 64'(46));
        @(negedge clk);
        check("b2b_cap_one_cycle", 64'(cap_valid), 64'(0));

        // load_valid while busy is ignored
        frame(42'h0F0F0F0F0F0, 42'h0F0F0F0F0F0, 10, 0, c1);
        @(negedge clk);
        check("glitch_no_second_cap", 64'(cap_valid), 64'(0));
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (cap_valid) seen++;
            @(negedge clk);
        end
        check("glitch_no_extra_cap", 64'(seen), 64'(0));

        // reset mid-frame aborts without a capture
        frame(42'h3C3C3C3C3C3, 42'h3C3C3C3C3C3, 0, 20, c1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (cap_valid || ser_valid) seen++;
            @(negedge clk);
        end
        check("abort_no_cap", 64'(seen), 64'(0));
        frame(42'h00000000155, 42'h00000000155, 0, 0, c1);
        @(negedge clk);

        // random words with random idle gaps
        for (int n = 0; n < 100; n++) begin
            gap = int'($urandom_range(10, 0));
            repeat (gap) @(negedge clk);
            w = W'({$urandom(), $urandom()});
            frame(w, w, 0, 0, c1);
        end
        @(negedge clk);
        check("final_cap_one_cycle", 64'(cap_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/piso_harness.md
PISO_HARNESS -- requirements
Module: piso_harness

Interface
REQ-001 SHALL have parameter WIDTH, default 42, giving the parallel word width in bits (>=1).
REQ-002 SHALL have parameter EXTRA_BITS, default 3, giving the zero pad bits appended after each serialized word (>=0).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port load_valid, input, 1, requesting a parallel load.
REQ-006 SHALL have port load_data, input, WIDTH, the word to serialize.
REQ-007 SHALL have port load_ready, output, 1, high when a load can be accepted.
REQ-008 SHALL have port ser_out, output, 1, the serial bit stream.
REQ-009 SHALL have port ser_valid, output, 1, high while ser_out carries a frame bit (data or pad).
REQ-010 SHALL have port cap_valid, output, 1, a one-cycle pulse when a word has been reassembled.
REQ-011 SHALL have port cap_data, output, WIDTH, the reassembled word, held until the next cap_valid.

Function
REQ-012 SHALL accept a load on a rising edge where load_valid and load_ready are both high; load_data is latched then.
REQ-013 SHALL hold load_ready high only while idle; load_valid SHALL be ignored while busy.
REQ-014 SHALL make each frame WIDTH data bits, LSB first (load_data[0] first), followed by EXTRA_BITS zero bits.
REQ-015 SHALL present the frame bits on ser_out with ser_valid high in cycles 1..WIDTH+EXTRA_BITS after the accepting edge (cycle 0), one bit per cycle.
REQ-016 SHALL drive ser_out=0 and ser_valid=0 when no frame bit is presented.
REQ-017 SHALL have the capture side shift in ser_out during the WIDTH data cycles only and discard pad bits.
REQ-018 SHALL pulse cap_valid for exactly one cycle in cycle WIDTH+EXTRA_BITS+1, with cap_data equal to the loaded word.
REQ-019 SHALL raise load_ready in the same cycle as cap_valid, so a back-to-back load can be accepted on that edge.
REQ-020 SHALL produce identical results for any number of idle cycles between loads.
REQ-021 SHALL, when EXTRA_BITS=0, emit no pad and pulse cap_valid in cycle WIDTH+1.
REQ-022 SHALL use a frame bit counter sized $clog2(WIDTH+EXTRA_BITS+1) that stops, never wraps, at the terminal count.

Reset
REQ-023 SHALL, with rst high at a clock edge, set load_ready=1, ser_out=0, ser_valid=0, cap_valid=0 and cap_data=0.
REQ-024 SHALL, on reset mid-frame, abort the frame with no cap_valid for it and return to idle.
REQ-025 SHALL ignore load_valid in any cycle where rst is high.

Structure
REQ-026 SHALL need no shared package; widths derive from WIDTH and EXTRA_BITS as local constants.
REQ-027 SHALL implement the serializer as sub-module piso_shift_reg (parameters WIDTH, EXTRA_BITS; ports clk, rst, load, din, dout, dvalid, busy).
REQ-028 SHALL implement the capture shifter and its bit counter inline in piso_harness.

Verification
REQ-029 SHALL verify reset: rst for 7 cycles -> load_ready=1, ser_valid=0, cap_valid=0, cap_data=0.
REQ-030 SHALL verify a single load of 0x2AAAAAAAAAA -> ser_out 0,1,0,1,... for 42 cycles then 0,0,0, and cap_valid in cycle 46 with cap_data=0x2AAAAAAAAAA.
REQ-031 SHALL verify a back-to-back load of 0x3FFFFFFFFFF, then 0x00000000001 on the cap_valid edge -> two captures exactly 46 cycles apart, both words exact.
REQ-032 SHALL verify a load_valid pulse with 0x123 in cycle 10 of a frame -> ignored; only the first word is captured.
REQ-033 SHALL verify rst asserted in cycle 20 of a frame -> no cap_valid, load_ready=1 next cycle, and a subsequent load of 0x155 is captured correctly.
REQ-034 SHALL verify 100 random 42-bit words with 0-10 random idle cycles between loads -> every cap_data equals its loaded word and the failure count is 0.
